// File: rtl/focus_phase_buffer_if.sv
// Calculator-to-buffer phase stream plus the PWM-side read port and status.
// master: calculator/readout side, slave: the ping-pong buffer.
interface focus_phase_buffer_if #(
    parameter int PHASE_W = 8
);
    logic               START;
    logic [PHASE_W-1:0] PHASE_IN;
    logic               PHASE_VALID;
    logic               CLR_ERR;
    logic [7:0]         RD_ADDR;
    logic [PHASE_W-1:0] RD_PHASE;
    logic               BANK_SEL;
    logic               UPDATE;
    logic               BUSY;
    logic [15:0]        FRAME_CNT;
    logic               OVERFLOW;
    logic               SHORT_FRAME;

    modport master (
        output START, PHASE_IN, PHASE_VALID, CLR_ERR, RD_ADDR,
        input  RD_PHASE, BANK_SEL, UPDATE, BUSY, FRAME_CNT, OVERFLOW, SHORT_FRAME
    );

    modport slave (
        input  START, PHASE_IN, PHASE_VALID, CLR_ERR, RD_ADDR,
        output RD_PHASE, BANK_SEL, UPDATE, BUSY, FRAME_CNT, OVERFLOW, SHORT_FRAME
    );
endinterface

// File: rtl/focus_phase_buffer.sv
// Ping-pong phase buffer: the calculator fills the shadow bank, a completed
// frame is swapped in atomically, and the output stage reads the active bank.
module focus_phase_buffer #(
    parameter int TRANS_NUM = 249,
    parameter int PHASE_W   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    focus_phase_buffer_if.slave  bus
);
    localparam int              AW   = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
    localparam logic [7:0]      LAST = 8'(TRANS_NUM - 1);
    localparam logic [8:0]      NUM9 = 9'(TRANS_NUM);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t             state, state_nx;
    logic [7:0]         wr_idx, wr_idx_nx;
    logic [7:0]         wr_addr;
    logic               wr_en, commit, ovf_ev, short_ev;
    logic               bank_sel, valid_seen, overflow, short_frame;
    logic [15:0]        frame_cnt;
    logic [PHASE_W-1:0] bank0 [0:TRANS_NUM-1];
    logic [PHASE_W-1:0] bank1 [0:TRANS_NUM-1];
    logic [PHASE_W-1:0] rd_raw;
    logic               rd_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // START always wins: restart at index 0, consuming a same-cycle strobe.
    always_comb begin
        state_nx  = state;
        wr_idx_nx = wr_idx;
        wr_addr   = wr_idx;
        wr_en     = 1'b0;
        commit    = 1'b0;
        ovf_ev    = 1'b0;
        short_ev  = 1'b0;
        if (bus.START) begin
            state_nx  = FILL;
            wr_addr   = '0;
            wr_en     = bus.PHASE_VALID;
            wr_idx_nx = bus.PHASE_VALID ? 8'd1 : 8'd0;
            short_ev  = (state == FILL) && (wr_idx != 8'd0);
        end else begin
            case (state)
                IDLE:   ovf_ev = bus.PHASE_VALID;
                FILL: begin
                    if (bus.PHASE_VALID) begin
                        wr_en = 1'b1;
                        if (wr_idx == LAST) begin
                            commit    = 1'b1;
                            state_nx  = COMMIT;
                            wr_idx_nx = '0;
                        end else begin
                            wr_idx_nx = wr_idx + 8'd1;
                        end
                    end
                end
                COMMIT: begin
                    state_nx = IDLE;
                    ovf_ev   = bus.PHASE_VALID;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // The swap is registered on the last write, so the COMMIT cycle already
    // presents the new bank and the next read samples it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_idx      <= '0;
            bank_sel    <= 1'b0;
            frame_cnt   <= '0;
            valid_seen  <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            wr_idx      <= wr_idx_nx;
            overflow    <= ovf_ev   | (overflow    & ~bus.CLR_ERR);
            short_frame <= short_ev | (short_frame & ~bus.CLR_ERR);
            if (commit) begin
                bank_sel   <= ~bank_sel;
                frame_cnt  <= frame_cnt + 16'd1;
                valid_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            if (bank_sel) bank0[wr_addr[AW-1:0]] <= bus.PHASE_IN;
            else          bank1[wr_addr[AW-1:0]] <= bus.PHASE_IN;
        end
    end

    // Raw RAM read stays unreset; a reset-able qualifier masks it to zero.
    always_ff @(posedge CLK) begin
        rd_raw <= bank_sel ? bank1[bus.RD_ADDR[AW-1:0]] : bank0[bus.RD_ADDR[AW-1:0]];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rd_ok <= 1'b0;
        else     rd_ok <= valid_seen && ({1'b0, bus.RD_ADDR} < NUM9);
    end

    assign bus.RD_PHASE    = rd_ok ? rd_raw : '0;
    assign bus.BANK_SEL    = bank_sel;
    assign bus.UPDATE      = (state == COMMIT);
    assign bus.BUSY        = (state == FILL);
    assign bus.FRAME_CNT   = frame_cnt;
    assign bus.OVERFLOW    = overflow;
    assign bus.SHORT_FRAME = short_frame;
endmodule

// File: tb/tb_focus_phase_buffer.sv
// Directed scenarios plus a random phase stream, checked every cycle against
// a frame-level model of the ping-pong buffer.
module tb_focus_phase_buffer;
    localparam int TN = 249;
    localparam int PW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    focus_phase_buffer_if #(.PHASE_W(PW)) ifc();

    focus_phase_buffer #(.TRANS_NUM(TN), .PHASE_W(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a frame is either being filled or not; a full
    // frame flips which bank is visible.
    logic        m_fill = 1'b0;
    int          m_idx  = 0;
    logic        m_bank = 1'b0;
    logic [15:0] m_cnt  = '0;
    logic        m_ovf = 1'b0, m_short = 1'b0, m_seen = 1'b0, m_upd = 1'b0;
    logic [7:0]  m_rd   = '0;
    logic [7:0]  mmem [2][256];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_fill <= 1'b0; m_idx <= 0; m_bank <= 1'b0; m_cnt <= '0;
            m_ovf <= 1'b0; m_short <= 1'b0; m_seen <= 1'b0; m_upd <= 1'b0; m_rd <= '0;
        end else begin
            m_rd    <= (m_seen && int'(ifc.RD_ADDR) < TN) ? mmem[m_bank][ifc.RD_ADDR] : 8'h00;
            m_upd   <= 1'b0;
            m_ovf   <= (ifc.PHASE_VALID && !ifc.START && !m_fill) || (m_ovf && !ifc.CLR_ERR);
            m_short <= (ifc.START && m_fill && m_idx > 0) || (m_short && !ifc.CLR_ERR);
            if (ifc.START) begin
                m_fill <= 1'b1;
                m_idx  <= ifc.PHASE_VALID ? 1 : 0;
                if (ifc.PHASE_VALID) mmem[~m_bank][0] <= ifc.PHASE_IN;
            end else if (m_fill && ifc.PHASE_VALID) begin
                mmem[~m_bank][8'(m_idx)] <= ifc.PHASE_IN;
                if (m_idx == TN - 1) begin
                    m_fill <= 1'b0; m_idx <= 0; m_bank <= ~m_bank;
                    m_cnt <= m_cnt + 16'd1; m_seen <= 1'b1; m_upd <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("RD_PHASE",    ifc.RD_PHASE,    m_rd);
            chk("BANK_SEL",    ifc.BANK_SEL,    m_bank);
            chk("UPDATE",      ifc.UPDATE,      m_upd);
            chk("BUSY",        ifc.BUSY,        m_fill);
            chk("FRAME_CNT",   ifc.FRAME_CNT,   m_cnt);
            chk("OVERFLOW",    ifc.OVERFLOW,    m_ovf);
            chk("SHORT_FRAME", ifc.SHORT_FRAME, m_short);
        end
        if (ifc.UPDATE === 1'b1) upd_seen++;
    end

    task automatic cyc(input logic s, input logic pv, input logic [7:0] d,
                       input logic clr, input logic [7:0] a);
        ifc.START = s; ifc.PHASE_VALID = pv; ifc.PHASE_IN = d;
        ifc.CLR_ERR = clr; ifc.RD_ADDR = a;
        @(posedge CLK); #2;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, a);
        chk(name, ifc.RD_PHASE, exp);
    endtask

    task automatic strobes(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, d, 1'b0, 8'h00);
    endtask

    int u0;
    int fc0;

    initial begin
        ifc.START = 1'b0; ifc.PHASE_VALID = 1'b0; ifc.PHASE_IN = '0;
        ifc.CLR_ERR = 1'b0; ifc.RD_ADDR = '0;
        RST = 1'b1;
        @(posedge CLK); #2;
        chk_en = 1'b1;
        chk("rst_busy", ifc.BUSY, 0);
        chk("rst_bank", ifc.BANK_SEL, 0);
        chk("rst_cnt", ifc.FRAME_CNT, 0);
        chk("rst_rd", ifc.RD_PHASE, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        RST = 1'b0;

        // Full frame with phase = index
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("full_busy", ifc.BUSY, 1);
        for (int i = 0; i < TN; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
        chk("full_update", ifc.UPDATE, 1);
        chk("full_bank", ifc.BANK_SEL, 1);
        chk("full_cnt", ifc.FRAME_CNT, 1);
        chk("full_busy_commit", ifc.BUSY, 0);
        rd_chk("full_rd10", 8'h10, 8'h10);
        chk("full_update_gone", ifc.UPDATE, 0);
        rd_chk("full_rd248", 8'd248, 8'hF8);
        rd_chk("full_rd249", 8'd249, 8'h00);
        rd_chk("full_rd255", 8'd255, 8'h00);

        // Atomic swap: A=0x55 active while B=0xAA fills
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        strobes(TN, 8'h55);
        rd_chk("swapA_rd", 8'd7, 8'h55);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'd3);
        chk("swap_start_rd", ifc.RD_PHASE, 8'h55);
        for (int i = 0; i < TN; i++) begin
            cyc(1'b0, 1'b1, 8'hAA, 1'b0, 8'(i));
            chk("swap_old", ifc.RD_PHASE, 8'h55);
        end
        chk("swap_update", ifc.UPDATE, 1);
        rd_chk("swap_new", 8'd5, 8'hAA);
        chk("swap_cnt", ifc.FRAME_CNT, 3);

        // Short frame then full frame
        u0 = upd_seen;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        strobes(100, 8'h77);
        chk("short_before", ifc.SHORT_FRAME, 0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("short_set", ifc.SHORT_FRAME, 1);
        for (int i = 0; i < TN; i++) cyc(1'b0, 1'b1, 8'(i) ^ 8'h5A, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("short_one_update", upd_seen - u0, 1);
        chk("short_cnt", ifc.FRAME_CNT, 4);
        for (int i = 0; i < TN; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'(i));
            chk("short_data", ifc.RD_PHASE, 8'(i) ^ 8'h5A);
        end

        // Overflow and clear priority
        cyc(1'b0, 1'b1, 8'hEE, 1'b0, 8'h00);
        chk("ovf_set", ifc.OVERFLOW, 1);
        rd_chk("ovf_rd0", 8'd0, 8'h5A);
        rd_chk("ovf_rd100", 8'd100, 8'd100 ^ 8'h5A);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("ovf_clr", ifc.OVERFLOW, 0);
        chk("short_clr", ifc.SHORT_FRAME, 0);
        cyc(1'b0, 1'b1, 8'hEE, 1'b1, 8'h00);
        chk("ovf_clr_collide", ifc.OVERFLOW, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("ovf_clr2", ifc.OVERFLOW, 0);

        // Simultaneous START + PHASE_VALID
        cyc(1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
        chk("sim_busy", ifc.BUSY, 1);
        chk("sim_no_ovf", ifc.OVERFLOW, 0);
        strobes(TN - 1, 8'h11);
        chk("sim_update", ifc.UPDATE, 1);
        rd_chk("sim_rd0", 8'd0, 8'h3C);
        rd_chk("sim_rd1", 8'd1, 8'h11);
        rd_chk("sim_rd248", 8'd248, 8'h11);
        chk("sim_cnt", ifc.FRAME_CNT, 5);

        // Reset mid-fill
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        strobes(50, 8'h99);
        chk("rstmid_busy", ifc.BUSY, 1);
        #1 RST = 1'b1;
        #1;
        chk("rstmid_busy0", ifc.BUSY, 0);
        chk("rstmid_bank", ifc.BANK_SEL, 0);
        chk("rstmid_cnt", ifc.FRAME_CNT, 0);
        chk("rstmid_upd", ifc.UPDATE, 0);
        chk("rstmid_rd", ifc.RD_PHASE, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        RST = 1'b0;
        u0 = upd_seen;
        for (int i = 0; i < 12; i++) rd_chk("rstmid_rd_zero", 8'(i * 21), 8'h00);
        strobes(10, 8'h99);
        chk("rstmid_no_update", upd_seen - u0, 0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        strobes(TN, 8'h42);
        chk("rstmid_frame_update", ifc.UPDATE, 1);
        rd_chk("rstmid_frame_rd", 8'd123, 8'h42);

        // Random phase stream
        fc0 = int'(ifc.FRAME_CNT);
        for (int i = 0; i < 5000; i++) begin
            cyc(($urandom_range(0, 399) == 0) || (i == 0),
                ($urandom_range(0, 7) != 0),
                8'($urandom),
                ($urandom_range(0, 49) == 0),
                8'($urandom));
        end
        chk("rand_progress", (int'(ifc.FRAME_CNT) > fc0) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
